// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, bubble
// encoding, FSM state codes and the jump-target helper.
package if_fetch_stage_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP = '0;

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Region bits come from the PC+4 of the jump itself, which is what IF/ID holds.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Decode/InstMem-facing bundle of the fetch stage; master is the fetch stage.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic              Stall;
  logic              Branch;
  logic [31:0]       BranchTarget;
  logic              Jump;
  logic [25:0]       JumpIndex;
  logic [INST_W-1:0] InstIn;
  logic [31:0]       Pc;
  logic [INST_W-1:0] IfIdInst;
  logic [31:0]       IfIdPcPlus4;
  logic              IfIdValid;
  logic              AddrErr;

  modport master (
    input  Stall, Branch, BranchTarget, Jump, JumpIndex, InstIn,
    output Pc, IfIdInst, IfIdPcPlus4, IfIdValid, AddrErr
  );

  modport slave (
    output Stall, Branch, BranchTarget, Jump, JumpIndex, InstIn,
    input  Pc, IfIdInst, IfIdPcPlus4, IfIdValid, AddrErr
  );

endinterface

// File: rtl/if_fetch_stage_pc_next_mux.sv
// Next-PC selection: Jump > Branch > Stall > sequential, plus the
// misaligned-branch flag that only counts when Jump does not win.
module pc_next_mux
  import if_fetch_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] ifid_pc_plus4_i,
  input  logic [31:0] branch_target_i,
  input  logic [25:0] jump_index_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        stall_i,
  output logic [31:0] pc_next_o,
  output logic [31:0] pc_plus4_o,
  output logic        redirect_o,
  output logic        misalign_o
);

  always_comb begin
    pc_plus4_o = pc_i + 32'd4;
    redirect_o = jump_i | branch_i;
    misalign_o = branch_i & ~jump_i & (|branch_target_i[1:0]);
    if (jump_i) begin
      pc_next_o = jump_target(ifid_pc_plus4_i, jump_index_i);
    end else if (branch_i) begin
      pc_next_o = {branch_target_i[31:2], 2'b00};
    end else if (stall_i) begin
      pc_next_o = pc_i;
    end else begin
      pc_next_o = pc_plus4_o;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, FILL/RUN/HOLD
// control and sticky address-error flag.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input logic              Clk,
  input logic              Rst,
  if_fetch_stage_if.master bus
);

  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  logic [1:0]        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       pp4_q, pp4_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic        stall_eff;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        misalign;
  logic        out_of_range;

  // The FILL cycle must load unconditionally, so Stall is masked there.
  assign stall_eff    = bus.Stall & (state_q != FILL);
  assign out_of_range = ({1'b0, pc_q} >= IMEM_BYTES);

  pc_next_mux u_pc_next_mux (
    .pc_i            (pc_q),
    .ifid_pc_plus4_i (pp4_q),
    .branch_target_i (bus.BranchTarget),
    .jump_index_i    (bus.JumpIndex),
    .jump_i          (bus.Jump),
    .branch_i        (bus.Branch),
    .stall_i         (stall_eff),
    .pc_next_o       (pc_d),
    .pc_plus4_o      (pc_plus4),
    .redirect_o      (redirect),
    .misalign_o      (misalign)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (redirect) begin
      inst_d  = NOP;
      valid_d = 1'b0;
      err_d   = err_q | misalign;
      state_d = RUN;
    end else if (stall_eff) begin
      state_d = HOLD;
    end else begin
      state_d = RUN;
      pp4_d   = pc_plus4;
      if (out_of_range) begin
        inst_d  = NOP;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end else begin
        inst_d  = bus.InstIn;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= FILL;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      pp4_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.Pc          = pc_q;
  assign bus.IfIdInst    = inst_q;
  assign bus.IfIdPcPlus4 = pp4_q;
  assign bus.IfIdValid   = valid_q;
  assign bus.AddrErr     = err_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table followed by random stimulus
// checked against a rule-level fetch model, with a preloaded InstMem.
module tb_if_fetch_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_stage_if bus();

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(1024)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);

  // Out-of-range reads return junk so a missing zero-fill is visible.
  always_comb begin
    if (bus.Pc < 32'd4096) bus.InstIn = mem[bus.Pc[11:2]];
    else                   bus.InstIn = 32'hDEAD_BEEF;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stall, branch, jump;
    logic [31:0] bt;
    logic [25:0] ji;
    logic [31:0] e_pc, e_inst, e_pp4;
    logic        e_valid, e_err;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic r, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [25:0] ji,
                      input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] pp4,
                      input logic v, input logic e);
    vec_t t;
    t.rst = r; t.stall = s; t.branch = b; t.bt = bt; t.jump = j; t.ji = ji;
    t.e_pc = pc; t.e_inst = inst; t.e_pp4 = pp4; t.e_valid = v; t.e_err = e;
    vq.push_back(t);
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [25:0] ji);
    rst = r; bus.Stall = s; bus.Branch = b; bus.BranchTarget = bt;
    bus.Jump = j; bus.JumpIndex = ji;
  endtask

  task automatic chk_all(input string pfx, input int idx, input logic [31:0] pc,
                         input logic [31:0] inst, input logic [31:0] pp4,
                         input logic v, input logic e);
    chk({pfx, "_pc"},    idx, bus.Pc, pc);
    chk({pfx, "_inst"},  idx, bus.IfIdInst, inst);
    chk({pfx, "_pp4"},   idx, bus.IfIdPcPlus4, pp4);
    chk({pfx, "_valid"}, idx, 32'(bus.IfIdValid), 32'(v));
    chk({pfx, "_err"},   idx, 32'(bus.AddrErr), 32'(e));
  endtask

  // Rule-level reference: what the stage should hold after each edge.
  logic [31:0] m_pc, m_inst, m_pp4;
  logic        m_valid, m_err, m_first;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                            input logic j, input logic [25:0] ji);
    logic [31:0] tgt;
    if (r) begin
      m_pc = 0; m_inst = 0; m_pp4 = 0; m_valid = 0; m_err = 0; m_first = 1;
      return;
    end
    if (j || b) begin
      if (j) tgt = {m_pp4[31:28], ji, 2'b00};
      else begin
        tgt = bt - (bt % 4);
        if (bt % 4 != 0) m_err = 1;
      end
      m_pc = tgt; m_inst = 0; m_valid = 0;
    end else if (!(s && !m_first)) begin
      if (m_pc >= 32'd4096) begin
        m_inst = 0; m_valid = 0; m_err = 1;
      end else begin
        m_inst = mword(m_pc); m_valid = 1;
      end
      m_pp4 = m_pc + 4;
      m_pc  = m_pc + 4;
    end
    m_first = 0;
  endtask

  initial begin
    vec_t t;
    logic r, s, b, j;
    logic [31:0] bt;
    logic [25:0] ji;

    drive(1, 0, 0, 0, 0, 0);

    //     rst stl br bt              jmp ji   pc            inst          pp4           v  e
    addv(1, 0, 0, 32'd0,          0, 0,  32'd0,        32'd0,        32'd0,        0, 0);
    addv(0, 0, 0, 32'd0,          0, 0,  32'd4,        32'h1000_0000, 32'd4,       1, 0);
    addv(0, 0, 0, 32'd0,          0, 0,  32'd8,        32'h1000_0001, 32'd8,       1, 0);
    addv(0, 1, 0, 32'd0,          0, 0,  32'd8,        32'h1000_0001, 32'd8,       1, 0);
    addv(0, 1, 0, 32'd0,          0, 0,  32'd8,        32'h1000_0001, 32'd8,       1, 0);
    addv(0, 0, 0, 32'd0,          0, 0,  32'd12,       32'h1000_0002, 32'd12,      1, 0);
    addv(0, 1, 1, 32'd40,         0, 0,  32'd40,       32'd0,        32'd12,       0, 0);
    addv(0, 0, 0, 32'd0,          0, 0,  32'd44,       32'h1000_000A, 32'd44,      1, 0);
    addv(0, 0, 1, 32'd12,         0, 0,  32'd12,       32'd0,        32'd44,       0, 0);
    addv(0, 0, 0, 32'd0,          0, 0,  32'd16,       32'h1000_0003, 32'h10,      1, 0);
    addv(0, 0, 1, 32'h0000_0003,  1, 5,  32'd20,       32'd0,        32'h10,       0, 0);
    addv(0, 0, 0, 32'd0,          0, 0,  32'd24,       32'h1000_0005, 32'd24,      1, 0);
    addv(0, 0, 1, 32'h0000_0FFE,  0, 0,  32'h0FFC,     32'd0,        32'd24,       0, 1);
    addv(0, 0, 0, 32'd0,          0, 0,  32'h1000,     32'h1000_03FF, 32'h1000,    1, 1);
    addv(0, 0, 0, 32'd0,          0, 0,  32'h1004,     32'd0,        32'h1004,     0, 1);
    addv(0, 0, 1, 32'd0,          0, 0,  32'd0,        32'd0,        32'h1004,     0, 1);
    addv(0, 0, 0, 32'd0,          0, 0,  32'd4,        32'h1000_0000, 32'd4,       1, 1);
    addv(0, 1, 0, 32'd0,          0, 0,  32'd4,        32'h1000_0000, 32'd4,       1, 1);
    addv(1, 1, 1, 32'd40,         0, 0,  32'd0,        32'd0,        32'd0,        0, 0);
    addv(0, 1, 0, 32'd0,          0, 0,  32'd4,        32'h1000_0000, 32'd4,       1, 0);
    addv(0, 1, 0, 32'd0,          0, 0,  32'd4,        32'h1000_0000, 32'd4,       1, 0);
    addv(0, 0, 1, 32'hFFFF_FFFC,  0, 0,  32'hFFFF_FFFC, 32'd0,       32'd4,        0, 0);
    addv(0, 0, 0, 32'd0,          0, 0,  32'd0,        32'd0,        32'd0,        0, 1);
    addv(0, 0, 0, 32'd0,          0, 0,  32'd4,        32'h1000_0000, 32'd4,       1, 1);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      t = vq[i];
      drive(t.rst, t.stall, t.branch, t.bt, t.jump, t.ji);
      @(posedge clk); #1;
      chk_all("vec", i, t.e_pc, t.e_inst, t.e_pp4, t.e_valid, t.e_err);
    end

    // Random phase: starts from reset, then mixed stalls/redirects/resets.
    for (int n = 0; n < 3000; n++) begin
      r  = (n == 0) || ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 7) == 0);
      j  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       bt = $urandom;
        1:       bt = 32'h0FF0 + $urandom_range(0, 15);
        2:       bt = $urandom_range(0, 4095);
        default: bt = $urandom_range(0, 1023) * 4;
      endcase
      if ($urandom_range(0, 7) == 0) ji = 26'($urandom);
      else                           ji = 26'($urandom_range(0, 1100));
      drive(r, s, b, bt, j, ji);
      model_step(r, s, b, bt, j, ji);
      @(posedge clk); #1;
      chk_all("rnd", n, m_pc, m_inst, m_pp4, m_valid, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
